// File: rtl/lcd_gpio_pio_if.sv
// Avalon-MM slave bus bundle for the LCD GPIO port: 3-bit word address, 32-bit data,
// active-low strobes and registered read data.
interface lcd_gpio_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output read_n,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  read_n,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/lcd_gpio_pio.sv
// Parametrised GPIO port for LCD control lines: per-bit direction, atomic set/clear,
// synchronised inputs, sticky edge capture and a maskable level interrupt.
module lcd_gpio_pio #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0,
    parameter int unsigned      EDGE_TYPE   = 0,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    lcd_gpio_pio_if.slave    bus,
    input  logic [WIDTH-1:0] gpio_in_i,
    output logic [WIDTH-1:0] gpio_out_o,
    output logic [WIDTH-1:0] gpio_oe_o,
    output logic             irq_o
);

    localparam int unsigned ArmMax = SYNC_STAGES + 1;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] prev_q;
    logic [2:0]       arm_q;
    logic             armed;
    logic [WIDTH-1:0] edge_raw, edge_det;

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic             irq_q;
    logic [31:0]      rdata_q, rdata_d;

    logic             wr_en, rd_en;
    logic [WIDTH-1:0] wdata;
    logic             unused_wdata;

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign rd_en        = bus.chipselect & ~bus.read_n;
    assign wdata        = bus.writedata[WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;
    assign sync_in      = sync_q[SYNC_STAGES-1];
    assign armed        = (arm_q == ArmMax[2:0]);

    // Arming counter keeps a pin held high through reset from looking like a rising edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
            arm_q  <= '0;
        end else begin
            sync_q[0] <= gpio_in_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_in;
            if (!armed) arm_q <= arm_q + 3'd1;
        end
    end

    always_comb begin
        if (EDGE_TYPE == 0) begin
            edge_raw = sync_in & ~prev_q;
        end else if (EDGE_TYPE == 1) begin
            edge_raw = ~sync_in & prev_q;
        end else begin
            edge_raw = sync_in ^ prev_q;
        end
        edge_det = armed ? edge_raw : '0;
    end

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        mask_d     = mask_q;
        // A new edge wins over a same-cycle W1C of the same bit
        cap_d      = cap_q | edge_det;
        if (wr_en) begin
            case (bus.address)
                3'd0:    data_out_d = wdata;
                3'd1:    dir_d      = wdata;
                3'd2:    mask_d     = wdata;
                3'd3:    cap_d      = (cap_q & ~wdata) | edge_det;
                3'd4:    data_out_d = data_out_q | wdata;
                3'd5:    data_out_d = data_out_q & ~wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = '0;
            case (bus.address)
                3'd0:    rdata_d[WIDTH-1:0] = (data_out_q & dir_q) | (sync_in & ~dir_q);
                3'd1:    rdata_d[WIDTH-1:0] = dir_q;
                3'd2:    rdata_d[WIDTH-1:0] = mask_q;
                3'd3:    rdata_d[WIDTH-1:0] = cap_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= RESET_OUT;
            dir_q      <= RESET_DIR;
            mask_q     <= '0;
            cap_q      <= '0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            irq_q      <= |(cap_q & mask_q);
            rdata_q    <= rdata_d;
        end
    end

    assign gpio_out_o   = data_out_q;
    assign gpio_oe_o    = dir_q;
    assign irq_o        = irq_q;
    assign bus.readdata = rdata_q;

endmodule

// File: tb/tb_lcd_gpio_pio.sv
// Bench for lcd_gpio_pio: three instances (rising/8, any-edge/8, rising/3) share one stimulus
// stream; a cycle model of the register map is compared every cycle, plus literal checks.
module tb_lcd_gpio_pio;

    logic        clk;
    logic        reset_n;
    logic        cs, rd_n, wr_n;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  gin;

    lcd_gpio_pio_if bus0 ();
    lcd_gpio_pio_if bus2 ();
    lcd_gpio_pio_if bus3 ();

    assign bus0.address = addr; assign bus0.chipselect = cs; assign bus0.read_n = rd_n;
    assign bus0.write_n = wr_n; assign bus0.writedata = wdata;
    assign bus2.address = addr; assign bus2.chipselect = cs; assign bus2.read_n = rd_n;
    assign bus2.write_n = wr_n; assign bus2.writedata = wdata;
    assign bus3.address = addr; assign bus3.chipselect = cs; assign bus3.read_n = rd_n;
    assign bus3.write_n = wr_n; assign bus3.writedata = wdata;

    logic [7:0] out0, oe0, out2, oe2;
    logic [2:0] out3, oe3;
    logic       irq0, irq2, irq3;

    lcd_gpio_pio #(.WIDTH(8), .RESET_OUT(8'hA5), .RESET_DIR(8'h0F), .EDGE_TYPE(0),
                   .SYNC_STAGES(2)) u0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0), .gpio_in_i(gin),
        .gpio_out_o(out0), .gpio_oe_o(oe0), .irq_o(irq0));
    lcd_gpio_pio #(.WIDTH(8), .RESET_OUT(8'hA5), .RESET_DIR(8'h0F), .EDGE_TYPE(2),
                   .SYNC_STAGES(2)) u2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2), .gpio_in_i(gin),
        .gpio_out_o(out2), .gpio_oe_o(oe2), .irq_o(irq2));
    lcd_gpio_pio #(.WIDTH(3), .RESET_OUT(3'b101), .RESET_DIR(3'b010), .EDGE_TYPE(0),
                   .SYNC_STAGES(2)) u3 (
        .clk(clk), .reset_n(reset_n), .bus(bus3), .gpio_in_i(gin[2:0]),
        .gpio_out_o(out3), .gpio_oe_o(oe3), .irq_o(irq3));

    logic [31:0] d_out [3], d_oe [3], d_rd [3];
    logic        d_irq [3];
    assign d_out[0] = {24'h0, out0}; assign d_oe[0] = {24'h0, oe0};
    assign d_out[1] = {24'h0, out2}; assign d_oe[1] = {24'h0, oe2};
    assign d_out[2] = {29'h0, out3}; assign d_oe[2] = {29'h0, oe3};
    assign d_rd[0] = bus0.readdata; assign d_rd[1] = bus2.readdata;
    assign d_rd[2] = bus3.readdata;
    assign d_irq[0] = irq0; assign d_irq[1] = irq2; assign d_irq[2] = irq3;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Model: register file per instance, pin history as a list of past samples
    logic [31:0] wm   [3] = '{32'hFF, 32'hFF, 32'h7};
    int          et   [3] = '{0, 2, 0};
    logic [31:0] ro   [3] = '{32'hA5, 32'hA5, 32'h5};
    logic [31:0] rdir [3] = '{32'h0F, 32'h0F, 32'h2};
    logic [31:0] m_out [3], m_dir [3], m_mask [3], m_cap [3], m_rd [3];
    logic        m_irq [3];
    logic [31:0] hist  [3];
    int          cyc;

    task automatic model_step();
        logic [31:0] s, p, e, wd;
        bit armed, wr, rd;
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                m_out[i] = ro[i]; m_dir[i] = rdir[i]; m_mask[i] = 0;
                m_cap[i] = 0; m_irq[i] = 0; m_rd[i] = 0; hist[i] = 0;
            end
            cyc = 0;
            return;
        end
        armed = (cyc >= 3);
        wr = cs && !wr_n;
        rd = cs && !rd_n;
        for (int i = 0; i < 3; i++) begin
            s  = hist[1] & wm[i];
            p  = hist[2] & wm[i];
            wd = wdata & wm[i];
            case (et[i])
                0:       e = s & ~p;
                1:       e = ~s & p;
                default: e = s ^ p;
            endcase
            e = armed ? (e & wm[i]) : 32'h0;
            m_irq[i] = (m_cap[i] & m_mask[i]) != 0;
            if (rd) begin
                case (addr)
                    3'd0:    m_rd[i] = (m_out[i] & m_dir[i]) | (s & ~m_dir[i]);
                    3'd1:    m_rd[i] = m_dir[i];
                    3'd2:    m_rd[i] = m_mask[i];
                    3'd3:    m_rd[i] = m_cap[i];
                    default: m_rd[i] = 0;
                endcase
            end
            if (wr && addr == 3'd3) m_cap[i] = (m_cap[i] & ~wd) | e;
            else                    m_cap[i] = m_cap[i] | e;
            if (wr) begin
                case (addr)
                    3'd0:    m_out[i] = wd;
                    3'd1:    m_dir[i] = wd;
                    3'd2:    m_mask[i] = wd;
                    3'd4:    m_out[i] = m_out[i] | wd;
                    3'd5:    m_out[i] = m_out[i] & ~wd;
                    default: ;
                endcase
            end
        end
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = {24'h0, gin};
        if (cyc < 3) cyc++;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("cyc_out%0d", i), d_out[i], m_out[i]);
            chk($sformatf("cyc_oe%0d", i), d_oe[i], m_dir[i]);
            chk($sformatf("cyc_irq%0d", i), {31'h0, d_irq[i]}, {31'h0, m_irq[i]});
            chk($sformatf("cyc_rd%0d", i), d_rd[i], m_rd[i]);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        addr = a; wdata = d; cs = 1'b1; wr_n = 1'b0;
        @(negedge clk);
        cs = 1'b0; wr_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a);
        addr = a; cs = 1'b1; rd_n = 1'b0;
        @(negedge clk);
        cs = 1'b0; rd_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; cs = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
        addr = '0; wdata = '0; gin = 8'hFF;
        idle(3);
        chk("rst_out", {24'h0, out0}, 32'hA5);
        chk("rst_oe", {24'h0, oe0}, 32'h0F);
        chk("rst_out_w3", {29'h0, out3}, 32'h5);
        reset_n = 1'b1;
        idle(10);
        bus_read(3'd3);
        chk("no_false_edge", bus0.readdata, 32'h00);
        bus_read(3'd0);
        chk("data_mixed", bus0.readdata, 32'hF5);
        chk("data_mixed_w3", bus3.readdata, 32'h5);

        bus_write(3'd0, 32'h00);
        chk("out_write", {24'h0, out0}, 32'h00);
        bus_write(3'd4, 32'h81);
        chk("out_set", {24'h0, out0}, 32'h81);
        bus_write(3'd5, 32'h01);
        chk("out_clear", {24'h0, out0}, 32'h80);

        bus_write(3'd2, 32'h04);
        gin = 8'h00;
        idle(5);
        bus_write(3'd3, 32'hFF);
        idle(2);
        gin = 8'h04;
        idle(3);
        chk("irq_not_yet", {31'h0, irq0}, 32'h0);
        idle(1);
        chk("irq_rise", {31'h0, irq0}, 32'h1);
        bus_read(3'd3);
        chk("cap_bit2", bus0.readdata, 32'h04);
        bus_write(3'd3, 32'h04);
        idle(1);
        chk("irq_w1c", {31'h0, irq0}, 32'h0);

        gin = 8'h0C;
        idle(2);
        bus_write(3'd3, 32'h08);
        bus_read(3'd3);
        chk("set_beats_clear", bus0.readdata, 32'h08);

        bus_write(3'd2, 32'h00);
        idle(4);
        bus_write(3'd3, 32'hFF);
        gin = 8'h2C;
        idle(4);
        gin = 8'h0C;
        idle(1);
        bus_write(3'd3, 32'h20);
        bus_read(3'd3);
        chk("any_cleared", bus2.readdata, 32'h00);
        idle(1);
        bus_read(3'd3);
        chk("any_fall", bus2.readdata, 32'h20);
        chk("rise_only", bus0.readdata, 32'h00);
        chk("any_irq_masked", {31'h0, irq2}, 32'h0);

        bus_write(3'd1, 32'hFFFF_FFFF);
        bus_read(3'd1);
        chk("dir_w3", bus3.readdata, 32'h7);
        chk("dir_w8", bus0.readdata, 32'hFF);
        bus_read(3'd6);
        chk("addr6_w3", bus3.readdata, 32'h0);

        reset_n = 1'b0;
        #1;
        chk("midrst_out", {24'h0, out0}, 32'hA5);
        chk("midrst_oe", {24'h0, oe0}, 32'h0F);
        @(negedge clk);
        reset_n = 1'b1;
        idle(5);
        bus_read(3'd0);
        chk("midrst_data", bus0.readdata, 32'h05);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
